alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 208 ++++++++++++++++++++
 tb/tb_alu_pipe.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle logic/arith/crypto ops, iterative mul/div.
// Define ALU_PIPE_DIV_EN to build the restoring divider.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [1:0]           mode,
    input  logic [2:0]           opcode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   outALU,
    output logic                 eq,
    output logic                 err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH:0] ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] res;
    logic               res_err;
    logic               accept;
    logic               op_mul;
    logic               op_div;
    logic               go_exec;
    logic               last;
    logic [SHW-1:0]     sh;
    logic [2*WIDTH-1:0] rot2;
    logic [WIDTH-1:0]   g2b;
    logic [WIDTH-1:0]   rev;

    assign accept = in_valid && in_ready;
    assign op_mul = (mode == 2'b01) && (opcode == 3'b010);
    assign op_div = (mode == 2'b01) && (opcode == 3'b011);
    assign last   = (cnt == CW'(WIDTH - 1));
    assign sh     = b[SHW-1:0];
    assign rot2   = {a, a} << sh;

`ifdef ALU_PIPE_DIV_EN
    logic             div_op;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] rem_n;
    assign go_exec = op_mul || (op_div && (b != '0));
`else
    assign go_exec = op_mul;
`endif

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            g2b[i] = ^(a >> i);
            rev[i] = a[WIDTH-1-i];
        end
    end

    always_comb begin
        res     = '0;
        res_err = 1'b0;
        unique case (mode)
            2'b00: begin
                case (opcode)
                    3'b000:  res[WIDTH-1:0] = a & b;
                    3'b001:  res[WIDTH-1:0] = a | b;
                    3'b010:  res[WIDTH-1:0] = a ^ b;
                    3'b011:  res[WIDTH-1:0] = ~a;
                    3'b100:  res[WIDTH-1:0] = ~(a & b);
                    3'b101:  res[WIDTH-1:0] = ~(a | b);
                    3'b110:  res[WIDTH-1:0] = ~(a ^ b);
                    default: res[1:0] = {a > b, a < b};
                endcase
            end
            2'b01: begin
                case (opcode)
                    3'b000:  res[WIDTH:0] = {1'b0, a} + {1'b0, b};
                    3'b001:  res[WIDTH:0] = {1'b0, a} - {1'b0, b};
                    3'b100:  res[WIDTH:0] = {1'b0, a} + ONE;
                    3'b101:  res[WIDTH:0] = {1'b0, a} - ONE;
                    3'b110:  res[WIDTH-1:0] = a << sh;
                    3'b111:  res[WIDTH-1:0] = a >> sh;
                    3'b011: begin
`ifdef ALU_PIPE_DIV_EN
                        res = {a, {WIDTH{1'b1}}};
`endif
                        res_err = 1'b1;
                    end
                    default: res = '0;
                endcase
            end
            2'b10: begin
                case (opcode)
                    3'b000:  res[WIDTH-1:0] = a ^ (a >> 1);
                    3'b001:  res[WIDTH-1:0] = g2b;
                    3'b010:  res[WIDTH-1:0] = rev;
                    3'b011:  res[WIDTH-1:0] = rot2[2*WIDTH-1:WIDTH];
                    default: res_err = 1'b1;
                endcase
            end
            default: res_err = 1'b1;
        endcase
    end

    // Multiply keeps {partial product, remaining multiplier} in acc;
    // divide keeps {remainder, quotient-so-far} in the same register.
    logic [WIDTH:0]     hi_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    assign hi_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                   + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_nxt = {hi_sum, acc[WIDTH-1:1]};

`ifdef ALU_PIPE_DIV_EN
    assign shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign ge      = (shifted >= {1'b0, opnd});
    assign diff    = shifted - {1'b0, opnd};
    assign rem_n   = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign acc_nxt = div_op ? {rem_n, acc[WIDTH-2:0], ge} : mul_nxt;
`else
    assign acc_nxt = mul_nxt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = go_exec ? EXEC : DONE;
                end
            end
            EXEC: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            outALU <= '0;
            eq     <= 1'b0;
            err    <= 1'b0;
`ifdef ALU_PIPE_DIV_EN
            div_op <= 1'b0;
`endif
        end else if (accept) begin
            eq  <= (a == b);
            cnt <= '0;
            if (go_exec) begin
                err <= 1'b0;
`ifdef ALU_PIPE_DIV_EN
                div_op <= op_div;
                acc    <= {{WIDTH{1'b0}}, op_div ? a : b};
                opnd   <= op_div ? b : a;
`else
                acc    <= {{WIDTH{1'b0}}, b};
                opnd   <= a;
`endif
            end else begin
                outALU <= res;
                err    <= res_err;
            end
        end else if (state == EXEC) begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (last) begin
                outALU <= acc_nxt;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_alu_pipe.sv
// Randomized + directed bench for alu_pipe (WIDTH=16) against a
// plain-arithmetic reference model.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  mode;
    logic [2:0]  opcode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] outALU;
    logic        eq;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    alu_pipe #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .opcode(opcode),
        .out_valid(out_valid), .out_ready(out_ready),
        .outALU(outALU), .eq(eq), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] m,
                                          input logic [2:0] op,
                                          input logic [15:0] xa,
                                          input logic [15:0] xb,
                                          output logic e,
                                          output int lat);
        int unsigned ua, ub, s, r, x;
        ua = xa; ub = xb; s = xb[3:0];
        e = 1'b0; lat = 1; r = 0;
        case (m)
            2'd0: case (op)
                3'd0: r = ua & ub;
                3'd1: r = ua | ub;
                3'd2: r = ua ^ ub;
                3'd3: r = ~ua & 16'hFFFF;
                3'd4: r = ~(ua & ub) & 16'hFFFF;
                3'd5: r = ~(ua | ub) & 16'hFFFF;
                3'd6: r = ~(ua ^ ub) & 16'hFFFF;
                default: r = ((ua > ub) ? 2 : 0) + ((ua < ub) ? 1 : 0);
            endcase
            2'd1: case (op)
                3'd0: r = ua + ub;
                3'd1: r = (ua - ub) & 32'h1FFFF;
                3'd4: r = ua + 1;
                3'd5: r = (ua - 1) & 32'h1FFFF;
                3'd2: begin r = ua * ub; lat = 17; end
                3'd3: begin
`ifdef ALU_PIPE_DIV_EN
                    if (ub == 0) begin
                        r = (ua << 16) | 32'hFFFF; e = 1'b1;
                    end else begin
                        r = ((ua % ub) << 16) | (ua / ub); lat = 17;
                    end
`else
                    r = 0; e = 1'b1;
`endif
                end
                3'd6: r = (ua << s) & 16'hFFFF;
                default: r = ua >> s;
            endcase
            2'd2: case (op)
                3'd0: r = ua ^ (ua >> 1);
                3'd1: begin
                    x = 0;
                    for (int i = 15; i >= 0; i--) begin
                        x = x ^ ((ua >> i) & 1);
                        r = r | (x << i);
                    end
                end
                3'd2: for (int i = 0; i < 16; i++)
                    r = r | (((ua >> i) & 1) << (15 - i));
                3'd3: r = ((ua << s) | (ua >> (16 - s))) & 16'hFFFF;
                default: begin r = 0; e = 1'b1; end
            endcase
            default: begin r = 0; e = 1'b1; end
        endcase
        return r;
    endfunction

    task automatic run_op(input logic [1:0] m, input logic [2:0] op,
                          input logic [15:0] xa, input logic [15:0] xb,
                          input int hold);
        logic [31:0] exp;
        logic        exp_err;
        int          exp_lat;
        int          lat;
        logic        busy_ok;
        exp = model(m, op, xa, xb, exp_err, exp_lat);
        @(negedge clk);
        in_valid = 1'b1; a = xa; b = xb; mode = m; opcode = op;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        mode = 2'($urandom); opcode = 3'($urandom);
        lat = 1; busy_ok = 1'b1;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("busy_in_ready", busy_ok, 1'b1);
        check("outALU", outALU, exp);
        check("eq", eq, xa == xb);
        check("err", err, exp_err);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1'b1);
            check("hold_outALU", outALU, exp);
            check("hold_err", err, exp_err);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_ready", in_ready, 1'b1);
        check("release_valid", out_valid, 1'b0);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [1:0]  rm;
        logic [2:0]  ro;
        logic [15:0] ra, rb;
        logic        stray;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; mode = '0; opcode = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_outALU", outALU, 32'h0);
        check("rst_eq", eq, 1'b0);
        check("rst_err", err, 1'b0);
        @(negedge clk); rst = 1'b0;

        run_op(2'b01, 3'b000, 16'hFFFF, 16'h0001, 0);
        run_op(2'b01, 3'b010, 16'hFFFF, 16'hFFFF, 0);
        run_op(2'b01, 3'b011, 16'h0064, 16'h0007, 1);
        run_op(2'b01, 3'b011, 16'h0064, 16'h0000, 0);
        run_op(2'b10, 3'b000, 16'h000B, 16'h0000, 4);
        run_op(2'b11, 3'b101, 16'h1234, 16'h1234, 0);
        run_op(2'b00, 3'b111, 16'h0003, 16'h0009, 0);
        run_op(2'b10, 3'b011, 16'h8001, 16'h0000, 0);
        run_op(2'b10, 3'b110, 16'h5555, 16'h5555, 0);

        @(negedge clk);
        in_valid = 1'b1; mode = 2'b01; opcode = 3'b010;
        a = 16'h1234; b = 16'h5678;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_outALU", outALU, 32'h0);
        @(negedge clk); rst = 1'b0;
        stray = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stray = 1'b1;
        end
        check("abort_no_result", stray, 1'b0);

        for (int n = 0; n < 80; n++) begin
            rm = 2'($urandom_range(0, 3));
            ro = 3'($urandom_range(0, 7));
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            if ($urandom_range(0, 7) == 0) rb = ra;
            if ($urandom_range(0, 3) == 0) rm = 2'b01;
            run_op(rm, ro, ra, rb, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
